// File: rtl/lut_func_pkg.sv
// Shared constants and helpers for the LUT-based Boolean function evaluator.
//   row_width()    : truth-table row width (and row count) for a given input width
//   identity_row() : reset contents of table row r (bit r set, all others clear)
package lut_func_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;
    // Widest row the block supports (N_IN = 8 -> HALF = 4 -> 16).
    localparam int unsigned MAX_ROW_W     = 16;

    function automatic int unsigned row_width(input int unsigned n_in);
        return 32'd1 << (n_in / 2);
    endfunction

    function automatic logic [MAX_ROW_W-1:0] identity_row(input int unsigned r);
        return MAX_ROW_W'(1) << r;
    endfunction

endpackage

// File: rtl/lut_func_eval_if.sv
// Bundle of the evaluator's configuration, input-stream, output-stream and counter signals.
//   master : producer / consumer / configuration side (drives cfg_*, in_valid, in_vec,
//            out_ready, cnt_clr)
//   slave  : the evaluator itself (drives in_ready, out_valid, out_f, hit_cnt)
interface lut_func_eval_if
    import lut_func_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
);
    localparam int unsigned HALF  = N_IN / 2;
    localparam int unsigned ROW_W = row_width(N_IN);

    logic             cfg_we;
    logic [HALF-1:0]  cfg_addr;
    logic [ROW_W-1:0] cfg_wdata;

    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_vec;

    logic             out_valid;
    logic             out_ready;
    logic             out_f;

    logic [CNT_W-1:0] hit_cnt;
    logic             cnt_clr;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, in_valid, in_vec, out_ready, cnt_clr,
        input  in_ready, out_valid, out_f, hit_cnt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_vec, out_ready, cnt_clr,
        output in_ready, out_valid, out_f, hit_cnt
    );

endinterface

// File: rtl/onehot_decoder.sv
// Purely combinational binary-to-one-hot decoder.
//   sel    : binary index, HALF bits
//   onehot : ROW_W bits, exactly bit 'sel' set
module onehot_decoder
    import lut_func_pkg::*;
#(
    parameter int unsigned HALF  = 2,
    parameter int unsigned ROW_W = row_width(2 * HALF)
) (
    input  logic [HALF-1:0]  sel,
    output logic [ROW_W-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/lut_func_eval.sv
// Two-stage pipelined Boolean function evaluator with a run-time writable truth table.
// The high half of in_vec selects a table row (via a one-hot decoder), the low half picks
// one bit of that row. Reset loads the identity table, i.e. F = (high half == low half).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.cfg_*  : table row write port (never stalls the pipeline)
//   bus.in_*   : input sample stream, valid/ready
//   bus.out_*  : result stream, valid/ready; out_f holds while stalled
//   bus.hit_cnt, bus.cnt_clr : saturating count of accepted F=1 results, sync clear
module lut_func_eval
    import lut_func_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    lut_func_eval_if.slave bus
);

    localparam int unsigned HALF  = N_IN / 2;
    localparam int unsigned ROW_W = row_width(N_IN);

    logic [ROW_W-1:0] table_q [ROW_W];

    logic [ROW_W-1:0] row_sel;
    logic [ROW_W-1:0] sel_row;

    logic             s1_valid_q;
    logic [ROW_W-1:0] s1_row_q;
    logic [HALF-1:0]  s1_low_q;

    logic             out_valid_q;
    logic             out_f_q;
    logic [CNT_W-1:0] hit_cnt_q;

    logic s2_free, s1_adv, in_ready, in_xfer, out_xfer;

    // ---------------- Flow control ----------------
    assign s2_free  = !out_valid_q || bus.out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign in_xfer  = bus.in_valid && in_ready;
    assign out_xfer = out_valid_q && bus.out_ready;

    // ---------------- Truth table ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < ROW_W; r++) begin
                table_q[r] <= ROW_W'(identity_row(r));
            end
        end else if (bus.cfg_we) begin
            table_q[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    // ---------------- Stage 1: row select ----------------
    onehot_decoder #(
        .HALF  (HALF),
        .ROW_W (ROW_W)
    ) u_dec (
        .sel    (bus.in_vec[N_IN-1:HALF]),
        .onehot (row_sel)
    );

    // Reads the pre-write table contents, so a sample accepted on the same edge as a
    // write to its row sees the old row.
    always_comb begin
        sel_row = '0;
        for (int unsigned r = 0; r < ROW_W; r++) begin
            sel_row = sel_row | (table_q[r] & {ROW_W{row_sel[r]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_row_q   <= '0;
            s1_low_q   <= '0;
        end else if (in_xfer) begin
            s1_valid_q <= 1'b1;
            s1_row_q   <= sel_row;
            s1_low_q   <= bus.in_vec[HALF-1:0];
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // ---------------- Stage 2: bit select ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_f_q     <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q <= 1'b1;
            out_f_q     <= s1_row_q[s1_low_q];
        end else if (out_xfer) begin
            out_valid_q <= 1'b0;
        end
    end

    // ---------------- Hit counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            hit_cnt_q <= '0;
        end else if (out_xfer && out_f_q && (hit_cnt_q != '1)) begin
            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_f     = out_f_q;
    assign bus.hit_cnt   = hit_cnt_q;

endmodule

// File: doc/lut_func_eval.md
# lut_func_eval

Parametrised, pipelined Boolean-function evaluator: an N_IN-bit input vector is split into a high half, which goes through a one-hot decoder to select a truth-table row, and a low half, which muxes one bit out of that row. The truth table is run-time writable. Reset loads the identity table, so the default function is F = (high half == low half). The block sits between an input producer and a result consumer, uses valid/ready on both sides, and keeps a saturating count of F=1 results.

## Interface
Parameters:
- N_IN, default 4: input vector width. Must be even, range 2..8. HALF = N_IN/2 and ROW_W = 2^HALF.
- CNT_W, default 16: width of the hit counter.

Ports:
- clk, in, 1: single clock. All logic is rising-edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- cfg_we, in, 1: table row write strobe.
- cfg_addr, in, HALF: row index to write.
- cfg_wdata, in, ROW_W: row contents. Bit c is F for low half == c.
- in_valid, in, 1: input sample valid.
- in_ready, out, 1: block accepts a sample this cycle.
- in_vec, in, N_IN: sample. The high half is in_vec[N_IN-1:HALF] and the low half is in_vec[HALF-1:0].
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- out_f, out, 1: function result.
- hit_cnt, out, CNT_W: count of accepted results with out_f=1.
- cnt_clr, in, 1: synchronous clear of hit_cnt.

## Operation
- Table: ROW_W rows of ROW_W bits, held in flops.
  - On reset, row r = one-hot(r), i.e. the identity table.
  - cfg_we=1 writes cfg_wdata into row cfg_addr at the clock edge.
  - Writes are legal every cycle and never stall the pipeline.
- Stage 1 (S1): on input transfer (in_valid and in_ready):
  - decode the high half to one-hot;
  - register the selected row (the OR of one-hot[r] AND row[r]);
  - register the low half;
  - set s1_valid.
- Stage 2 (S2): on advance, register out_f = row_reg[low_reg] and set out_valid.
- Flow control:
  - s2_free = !out_valid or out_ready.
  - S1 advances to S2 when s1_valid and s2_free.
  - in_ready = !s1_valid or s2_free. This is combinational and has no bubble.
  - Without backpressure, throughput is 1 sample per cycle.
- Output hold: while out_valid and !out_ready, out_f holds stable.
- Write/read ordering:
  - A sample takes its row value from the table as it stood before that edge's write.
  - A sample entering S1 on the same edge as a write to its row gets the old row.
  - Samples already in S1 or S2 are unaffected by later writes.
- hit_cnt:
  - Increments on each output transfer (out_valid and out_ready) with out_f=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority: clear and hit on the same cycle gives 0.
- Reset, including mid-stream, asynchronously forces:
  - s1_valid=0 and out_valid=0, so in-flight samples are discarded;
  - out_f=0 and hit_cnt=0;
  - the table back to identity.
  - in_ready=1 while and after reset.

## Timing
- Latency: a sample accepted at edge k produces out_valid=1 after edge k+1, when out_ready was high.
- Outputs after reset: out_valid=0, out_f=0, hit_cnt=0, in_ready=1.
- Capacity: at most 2 samples in flight. With out_ready held low, the third sample is refused (in_ready=0).
- Pipeline state per stage: empty or full. Full-to-empty happens only on advance or transfer.
- Combinational paths:
  - out_ready feeds in_ready.
  - No path from in_valid or in_vec to any output.

## Structure
- Package lut_func_pkg holds:
  - a function for ROW_W from N_IN;
  - a function returning the identity row for index r (reset value);
  - the CNT_W default constant.
- One sub-module: onehot_decoder, parametrised HALF to ROW_W. It has no enable and no clock, and is instantiated once in S1.
- The table, pipeline registers, flow control and counter stay in the top module.

## Test plan
- Reset defaults, N_IN=4: stream the inputs 0xA, 0xB, 0x0, 0x5 with out_ready=1. Required out_f sequence is 1, 0, 1, 1, each 2 cycles after acceptance. hit_cnt=3 after the last transfer.
- Custom table: write every row as 4'b0110 (XOR of the low bits), then stream all 16 vectors. Required out_f = in_vec[1]^in_vec[0] for every vector. hit_cnt=8.
- Backpressure: hold out_ready=0 with in_valid=1 continuously.
  - in_ready drops after 2 acceptances and out_f holds.
  - Release out_ready: 1 result per cycle, in order, with no loss or duplication.
- Write collision:
  - Write row 2 = 4'b0000 on the same edge that accepts vector 0x A: out_f=1 (old row).
  - The next 0xA gives out_f=0.
- Counter: CNT_W=4, 20 hits.
  - hit_cnt saturates at 15.
  - cnt_clr together with a hit gives 0.
  - The next hit gives 1.
- Reset mid-operation: assert rst_n=0 with 2 samples in flight and a modified table.
  - Immediately (asynchronously): out_valid=0, hit_cnt=0.
  - After release, input 0xF gives out_f=1 (identity table restored).
